perf_event_counters: RTL

//  Synthesizable, parametrised performance-monitor unit for the pipelined processor.

---
 rtl/perf_event_counters.sv | 115 +++++++++++
 1 files changed

// File: rtl/perf_event_counters.sv
// Performance-monitor counters: cycles, retired instructions and NUM_EVT
// generic events, with a RUN/HALTED freeze, sticky overflow flags and a
// registered single-counter read port.
module perf_event_counters #(
  parameter  int NUM_EVT  = 4,
  parameter  int CNT_W    = 32,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = $clog2(NUM_EVT + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 retire_i,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic                 halt_i,
  input  logic                 clr_i,
  input  logic                 rd_en_i,
  input  logic [SEL_W-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]     rd_data_o,
  output logic                 rd_valid_o,
  output logic [NUM_EVT+1:0]   ovf_o,
  output logic                 halted_o
);

  localparam int NCNT = NUM_EVT + 2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NCNT];
  logic [CNT_W-1:0]  cnt_d [NCNT];
  logic [NCNT-1:0]   ovf_q, ovf_d;
  logic [NCNT-1:0]   inc;
  logic [CNT_W-1:0]  rd_mux;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state: clear wins over a simultaneous halt
  always_comb begin
    state_d = state_q;
    if (clr_i)                          state_d = RUN;
    else if (state_q == RUN && halt_i)  state_d = HALTED;
  end

  // FSM outputs
  always_comb begin
    halted_o = (state_q == HALTED);
  end

  // Per-counter increment strobes; nothing counts while halted or clearing
  always_comb begin
    inc = {evt_i, retire_i, 1'b1};
    if (state_q != RUN || clr_i) inc = '0;
  end

  // Counter and overflow next-state, with wrap or saturate at all-ones
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Read mux over pre-update counter values; out-of-range selects yield 0
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_mux = cnt_q[i];
    end
    rd_data_d  = rd_en_i ? rd_mux : rd_data_q;
    rd_valid_d = rd_en_i;
  end

  // Counter, flag and read-port registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Registered outputs
  always_comb begin
    rd_data_o  = rd_data_q;
    rd_valid_o = rd_valid_q;
    ovf_o      = ovf_q;
  end

endmodule
